// File: rtl/kfps2kb_send_queue.sv
// kfps2kb_send_queue
//   Buffers host-to-device bytes for a PS/2 keyboard port and sends them one
//   at a time with the PS/2 host-to-device protocol:
//   inhibit -> request-to-send -> 10 device-clocked bits -> ACK -> line high.
//
// Parameters
//   INHIBIT_WAIT  peripheral_clock ticks spent in each of INHIBIT and REQUEST
//   TIMEOUT_WAIT  ticks allowed in SHIFT / WAIT_ACK / WAIT_HIGH before abort
//   DEPTH_LOG2    queue depth is 2**DEPTH_LOG2 bytes (1..6)
//
// Ports
//   clock, reset             system clock, async active-high reset
//   peripheral_clock         slow timebase, each synchronised rising edge = 1 tick
//   device_clock/device_data PS/2 lines as seen on the wire
//   device_clock_out/_data_out  registered open-drain controls (0 = pull low)
//   send_request, send_data  rising edge of send_request enqueues send_data
//   queue_full, queue_empty  queue status
//   sending_data_flag        high whenever a frame is in progress
//   send_done, send_error, overflow  single-cycle status pulses
//   debug_state              current FSM state
//   debug_ack_missing        device_data level captured at the ACK clock edge
//
// Build option
//   KFPS2KB_ACK_CHECK_EN     when defined, a missing ACK ends the frame with
//                            send_error instead of send_done.
//
// Handshake: send_request is edge-triggered, one byte per rising edge; a
// byte offered while the queue is full is dropped and overflow pulses.

module kfps2kb_send_queue #(
    parameter logic [15:0] INHIBIT_WAIT = 16'd240,
    parameter logic [15:0] TIMEOUT_WAIT = 16'd3000,
    parameter int          DEPTH_LOG2   = 2
) (
    input  logic       clock,
    input  logic       reset,
    input  logic       peripheral_clock,
    input  logic       device_clock,
    input  logic       device_data,
    output logic       device_clock_out,
    output logic       device_data_out,
    input  logic       send_request,
    input  logic [7:0] send_data,
    output logic       queue_full,
    output logic       queue_empty,
    output logic       sending_data_flag,
    output logic       send_done,
    output logic       send_error,
    output logic       overflow,
    output logic [2:0] debug_state,
    output logic       debug_ack_missing
);

    typedef enum logic [2:0] {
        IDLE      = 3'd0,
        INHIBIT   = 3'd1,
        REQUEST   = 3'd2,
        SHIFT     = 3'd3,
        WAIT_ACK  = 3'd4,
        WAIT_HIGH = 3'd5
    } state_t;

    localparam int                    DEPTH       = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   DEPTH_COUNT = DEPTH;
    localparam logic [DEPTH_LOG2:0]   COUNT_ONE   = 1;
    localparam logic [DEPTH_LOG2-1:0] PTR_ONE     = 1;

    // Queue storage and bookkeeping
    logic [7:0]            queue_mem [DEPTH];
    logic [DEPTH_LOG2-1:0] wr_ptr, rd_ptr;
    logic [DEPTH_LOG2:0]   count;
    logic [7:0]            head_byte;
    logic                  load_pending;
    logic                  prev_send_request;
    logic                  trigger, push, pop;

    // Timebase and line edge detection
    logic [2:0] peripheral_sync;
    logic       tick;
    logic       prev_device_clock;
    logic       clock_fall, clock_rise;

    // Frame FSM
    state_t      state, state_next;
    logic [15:0] state_counter;
    logic [3:0]  bit_count, bit_count_next;
    logic [9:0]  shift_register, shift_next;
    logic        ack_missing, ack_missing_next;
    logic        done_next, error_next, timed_out;
    logic        clock_out_next, data_out_next;

    assign trigger = send_request & ~prev_send_request;
    assign push    = trigger & ~queue_full;
    // A pop only starts when no byte is already waiting to be loaded.
    assign pop     = (state == IDLE) & ~load_pending & ~queue_empty;

    assign queue_full        = (count == DEPTH_COUNT);
    assign queue_empty       = (count == '0);
    assign sending_data_flag = (state != IDLE);
    assign debug_state       = state;
    assign debug_ack_missing = ack_missing;

    // Stages 0-1 synchronise peripheral_clock; stage 2 is the edge history.
    assign tick = peripheral_sync[1] & ~peripheral_sync[2];

    // device_clock is used directly: the wire is slow compared with clock,
    // and a single registered copy gives the edge history.
    assign clock_fall =  prev_device_clock & ~device_clock;
    assign clock_rise = ~prev_device_clock &  device_clock;

    assign timed_out = (state_counter >= TIMEOUT_WAIT);

    always_ff @(posedge clock) begin
        if (push) queue_mem[wr_ptr] <= send_data;
    end

    always_comb begin
        state_next       = state;
        shift_next       = shift_register;
        bit_count_next   = bit_count;
        ack_missing_next = ack_missing;
        done_next        = 1'b0;
        error_next       = 1'b0;

        case (state)
            IDLE: begin
                if (load_pending) begin
                    // start bit in bit 0, odd parity on top
                    shift_next     = {~^head_byte, head_byte, 1'b0};
                    bit_count_next = 4'd0;
                    state_next     = INHIBIT;
                end
            end
            INHIBIT: begin
                if (state_counter >= INHIBIT_WAIT) state_next = REQUEST;
            end
            REQUEST: begin
                if (state_counter >= INHIBIT_WAIT) state_next = SHIFT;
            end
            SHIFT: begin
                if (timed_out) begin
                    error_next = 1'b1;
                    state_next = IDLE;
                end else if (clock_fall) begin
                    // ones shifted in leave the stop bit on the line
                    shift_next     = {1'b1, shift_register[9:1]};
                    bit_count_next = bit_count + 4'd1;
                    if (bit_count == 4'd9) state_next = WAIT_ACK;
                end
            end
            WAIT_ACK: begin
                if (timed_out) begin
                    error_next = 1'b1;
                    state_next = IDLE;
                end else if (clock_fall) begin
                    ack_missing_next = device_data;
                    state_next       = WAIT_HIGH;
                end
            end
            WAIT_HIGH: begin
                if (timed_out) begin
                    error_next = 1'b1;
                    state_next = IDLE;
                end else if (clock_rise) begin
`ifdef KFPS2KB_ACK_CHECK_EN
                    error_next = ack_missing;
                    done_next  = ~ack_missing;
`else
                    done_next  = 1'b1;
`endif
                    state_next = IDLE;
                end
            end
            default: state_next = IDLE;
        endcase

        // Line drive follows the state being entered so the registered
        // outputs line up with the registered state.
        clock_out_next = 1'b1;
        data_out_next  = 1'b1;
        case (state_next)
            INHIBIT: clock_out_next = 1'b0;
            REQUEST: begin
                clock_out_next = 1'b0;
                data_out_next  = 1'b0;
            end
            SHIFT:   data_out_next = shift_next[0];
            default: ;
        endcase
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            state             <= IDLE;
            state_counter     <= '0;
            bit_count         <= '0;
            shift_register    <= '1;
            ack_missing       <= 1'b0;
            wr_ptr            <= '0;
            rd_ptr            <= '0;
            count             <= '0;
            head_byte         <= '0;
            load_pending      <= 1'b0;
            // Held high so a request level present across reset is not
            // mistaken for a fresh rising edge.
            prev_send_request <= 1'b1;
            peripheral_sync   <= '0;
            prev_device_clock <= 1'b0;
            device_clock_out  <= 1'b1;
            device_data_out   <= 1'b1;
            send_done         <= 1'b0;
            send_error        <= 1'b0;
            overflow          <= 1'b0;
        end else begin
            prev_send_request <= send_request;
            peripheral_sync   <= {peripheral_sync[1:0], peripheral_clock};
            prev_device_clock <= device_clock;

            if (push) wr_ptr <= wr_ptr + PTR_ONE;
            if (pop) begin
                rd_ptr    <= rd_ptr + PTR_ONE;
                head_byte <= queue_mem[rd_ptr];
            end
            load_pending <= pop;
            case ({push, pop})
                2'b10:   count <= count + COUNT_ONE;
                2'b01:   count <= count - COUNT_ONE;
                default: count <= count;
            endcase
            overflow <= trigger & queue_full;

            state          <= state_next;
            shift_register <= shift_next;
            bit_count      <= bit_count_next;
            ack_missing    <= ack_missing_next;
            if (state_next != state)
                state_counter <= '0;
            else if (tick)
                state_counter <= state_counter + 16'd1;

            device_clock_out <= clock_out_next;
            device_data_out  <= data_out_next;
            send_done        <= done_next;
            send_error       <= error_next;
        end
    end

endmodule

// File: tb/tb_kfps2kb_send_queue.sv
// Directed bench for kfps2kb_send_queue with a PS/2 device model and a byte
// scoreboard. Small INHIBIT/TIMEOUT values keep the run short; one
// peripheral tick is four system clocks.

module tb_kfps2kb_send_queue;

  localparam logic [15:0] INH = 16'd4;
  localparam logic [15:0] TMO = 16'd60;

  logic       clock = 1'b0;
  logic       reset = 1'b1;
  logic       peripheral_clock = 1'b0;
  logic       dev_clk = 1'b1;
  logic       dev_data = 1'b1;
  logic       send_request = 1'b0;
  logic [7:0] send_data = 8'h00;
  logic       device_clock, device_data;
  logic       device_clock_out, device_data_out;
  logic       queue_full, queue_empty, sending_data_flag;
  logic       send_done, send_error, overflow;
  logic [2:0] debug_state;
  logic       debug_ack_missing;

  // open-drain wires: either side can pull low
  assign device_clock = dev_clk & device_clock_out;
  assign device_data  = dev_data & device_data_out;

  kfps2kb_send_queue #(
    .INHIBIT_WAIT(INH),
    .TIMEOUT_WAIT(TMO),
    .DEPTH_LOG2(2)
  ) dut (
    .clock(clock),
    .reset(reset),
    .peripheral_clock(peripheral_clock),
    .device_clock(device_clock),
    .device_data(device_data),
    .device_clock_out(device_clock_out),
    .device_data_out(device_data_out),
    .send_request(send_request),
    .send_data(send_data),
    .queue_full(queue_full),
    .queue_empty(queue_empty),
    .sending_data_flag(sending_data_flag),
    .send_done(send_done),
    .send_error(send_error),
    .overflow(overflow),
    .debug_state(debug_state),
    .debug_ack_missing(debug_ack_missing)
  );

  // ---------------- clock / reset block ----------------
  always #5 clock = ~clock;
  always #20 peripheral_clock = ~peripheral_clock;

  int n_cmp = 0;
  int n_mis = 0;
  int done_cnt = 0;
  int err_cnt = 0;
  int ovf_cnt = 0;
  int cyc = 0;
  logic [7:0] exp_q[$];

  always @(negedge clock) begin
    cyc++;
    if (send_done === 1'b1) done_cnt++;
    if (send_error === 1'b1) err_cnt++;
    if (overflow === 1'b1) ovf_cnt++;
  end

  initial begin
    #2000000;
    $display("FAIL watchdog: observed=running expected=finished");
    $fatal(1, "watchdog expired");
  end

  // ---------------- checker ----------------
  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_mis++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // ---------------- driver tasks ----------------
  task automatic push_byte(input logic [7:0] b, input bit dropped);
    @(negedge clock);
    send_data = b;
    send_request = 1'b1;
    @(negedge clock);
    send_request = 1'b0;
    if (!dropped) exp_q.push_back(b);
  endtask

  task automatic wait_lines(input string tag, input logic c, input logic d, input int bound);
    bit seen;
    seen = 1'b0;
    for (int i = 0; i < bound; i++) begin
      if (device_clock_out === c && device_data_out === d) begin
        seen = 1'b1;
        break;
      end
      @(negedge clock);
    end
    chk(tag, seen, 1);
  endtask

  task automatic wait_pulse(input int bound, output bit got_done, output bit got_err);
    got_done = 1'b0;
    got_err = 1'b0;
    for (int i = 0; i < bound; i++) begin
      @(negedge clock);
      if (send_done === 1'b1 || send_error === 1'b1) begin
        got_done = send_done;
        got_err = send_error;
        break;
      end
    end
    chk("pulse_seen", got_done | got_err, 1);
  endtask

  // Device model: waits for request-to-send, then produces n_falls clock
  // pulses, sampling the data line while the clock is high before each fall.
  // With fewer than 11 falls the clock is left low on return.
  task automatic rx_frame(input int n_falls, input bit ack, output int req_len);
    logic [10:0] bits;
    logic [7:0] exp_b;
    int t0;
    bits = '1;
    wait_lines("req_entry", 1'b0, 1'b0, 400);
    t0 = cyc;
    wait_lines("shift_entry", 1'b1, 1'b0, 200);
    req_len = cyc - t0;
    for (int k = 0; k < n_falls; k++) begin
      repeat (4) @(negedge clock);
      bits[k] = device_data;
      if (k == 10 && ack) dev_data = 1'b0;
      dev_clk = 1'b0;
      if (k == n_falls - 1 && n_falls < 11) break;
      repeat (4) @(negedge clock);
      dev_clk = 1'b1;
      dev_data = 1'b1;
    end
    if (n_falls == 11) begin
      chk("sb_nonempty", (exp_q.size() > 0), 1);
      if (exp_q.size() > 0) begin
        exp_b = exp_q.pop_front();
        chk("frame_start", bits[0], 0);
        chk("frame_byte", bits[8:1], exp_b);
        chk("frame_parity", bits[9], ~^exp_b);
        chk("frame_stop", bits[10], 1);
      end
    end
  endtask

  // ---------------- directed sequence ----------------
  initial begin
    int req_len, d0, e0, o0, t_shift;
    bit gd, ge;
    logic [7:0] rb;

    // reset state
    repeat (3) @(negedge clock);
    chk("rst_clk_out", device_clock_out, 1);
    chk("rst_dat_out", device_data_out, 1);
    chk("rst_empty", queue_empty, 1);
    chk("rst_full", queue_full, 0);
    chk("rst_flag", sending_data_flag, 0);
    chk("rst_pulses", {send_done, send_error, overflow}, 0);
    chk("rst_state", debug_state, 0);
    reset = 1'b0;
    @(negedge clock);
    chk("idle_empty", queue_empty, 1);

    // single byte 0xED with ACK
    d0 = done_cnt;
    e0 = err_cnt;
    push_byte(8'hED, 1'b0);
    rx_frame(11, 1'b1, req_len);
    chk("req_len", (req_len >= 12 && req_len <= 20), 1);
    wait_pulse(20, gd, ge);
    chk("ed_done", gd, 1);
    chk("ed_err", ge, 0);
    repeat (4) @(negedge clock);
    chk("ed_done_once", done_cnt - d0, 1);
    chk("ed_no_err", err_cnt - e0, 0);
    chk("ed_ack_seen", debug_ack_missing, 0);
    chk("ed_lines", {device_clock_out, device_data_out}, 2'b11);
    chk("ed_flag", sending_data_flag, 0);

    // fill the queue behind a stalled frame, then overflow
    o0 = ovf_cnt;
    push_byte(8'h11, 1'b0);
    push_byte(8'h22, 1'b0);
    push_byte(8'h33, 1'b0);
    push_byte(8'h44, 1'b0);
    push_byte(8'h55, 1'b0);
    chk("q_full", queue_full, 1);
    push_byte(8'h66, 1'b1);
    repeat (2) @(negedge clock);
    chk("ovf_once", ovf_cnt - o0, 1);
    chk("q_full_held", queue_full, 1);
    for (int i = 0; i < 5; i++) begin
      rx_frame(11, 1'b1, req_len);
      wait_pulse(20, gd, ge);
      chk("fifo_done", gd, 1);
    end
    repeat (4) @(negedge clock);
    chk("fifo_empty", queue_empty, 1);
    chk("sb_drained", exp_q.size(), 0);

    // device never clocks: timeout, then the next byte goes out
    push_byte(8'hA5, 1'b0);
    push_byte(8'h3C, 1'b0);
    wait_lines("to_req", 1'b0, 1'b0, 400);
    wait_lines("to_shift", 1'b1, 1'b0, 200);
    t_shift = cyc;
    wait_pulse(400, gd, ge);
    chk("to_err", ge, 1);
    chk("to_no_done", gd, 0);
    chk("to_lines", {device_clock_out, device_data_out}, 2'b11);
    chk("to_time", ((cyc - t_shift) >= 230 && (cyc - t_shift) <= 252), 1);
    exp_q.delete(0);
    rx_frame(11, 1'b1, req_len);
    wait_pulse(20, gd, ge);
    chk("next_done", gd, 1);

    // no ACK from the device
    push_byte(8'h5A, 1'b0);
    rx_frame(11, 1'b0, req_len);
    wait_pulse(20, gd, ge);
`ifdef KFPS2KB_ACK_CHECK_EN
    chk("noack_err", ge, 1);
    chk("noack_done", gd, 0);
`else
    chk("noack_done", gd, 1);
    chk("noack_err", ge, 0);
`endif
    chk("noack_sample", debug_ack_missing, 1);

    // reset mid-frame with send_request held high
    push_byte(8'hC3, 1'b0);
    push_byte(8'h81, 1'b0);
    rx_frame(5, 1'b1, req_len);
    chk("mid_frame_flag", sending_data_flag, 1);
    send_data = 8'h99;
    send_request = 1'b1;
    @(posedge clock);
    #3;
    reset = 1'b1;
    #1;
    chk("arst_lines", {device_clock_out, device_data_out}, 2'b11);
    chk("arst_empty", queue_empty, 1);
    chk("arst_flag", sending_data_flag, 0);
    repeat (3) @(negedge clock);
    reset = 1'b0;
    dev_clk = 1'b1;
    exp_q.delete();
    repeat (10) @(negedge clock);
    chk("held_req_no_push", queue_empty, 1);
    chk("held_req_idle", sending_data_flag, 0);
    send_request = 1'b0;

    // push in the same cycle as a pop with one byte queued
    push_byte(8'h01, 1'b0);
    push_byte(8'h02, 1'b0);
    rx_frame(11, 1'b1, req_len);
    chk("pp_pre_nonempty", queue_empty, 0);
    wait_pulse(20, gd, ge);
    chk("pp_done", gd, 1);
    send_data = 8'h03;
    send_request = 1'b1;
    exp_q.push_back(8'h03);
    @(negedge clock);
    send_request = 1'b0;
    chk("pp_count_one", queue_empty, 0);
    chk("pp_not_full", queue_full, 0);
    for (int i = 0; i < 2; i++) begin
      rx_frame(11, 1'b1, req_len);
      wait_pulse(20, gd, ge);
      chk("pp_frame_done", gd, 1);
    end

    // random bytes carry the pointers around the ring again
    for (int i = 0; i < 6; i++) begin
      rb = 8'($urandom_range(0, 255));
      push_byte(rb, 1'b0);
      rx_frame(11, 1'b1, req_len);
      wait_pulse(20, gd, ge);
      chk("rand_done", gd, 1);
    end
    repeat (4) @(negedge clock);
    chk("final_empty", queue_empty, 1);
    chk("final_sb", exp_q.size(), 0);

    // ---------------- final report ----------------
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_mis);
    $finish;
  end

endmodule
